// File: rtl/cv32e40p_tb_ctrl_periph.sv
`timescale 1ns/1ps
// cv32e40p_tb_ctrl_periph
// Memory-mapped control responder sitting on the core data OBI port inside the
// testbench subsystem. Firmware writes stdout characters, an exit code and a
// pass/fail magic word; the results are presented as sticky flags to the bench
// top, and characters are queued in a FIFO for a printer to drain.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i/gnt_o              OBI address phase (req pre-decoded to this window)
//   addr_i, we_i, be_i,      OBI request attributes; only addr_i[4:2] selects
//   wdata_i                  a register
//   rvalid_o, rdata_o        OBI response, one cycle after each grant
//   stdout_valid_o/_char_o   FIFO head towards the printer
//   stdout_ready_i           printer accepts the head
//   tests_passed_o/_failed_o sticky pass / fail flags
//   exit_valid_o/_value_o    sticky exit request and first exit code
//
// Handshakes: a request is transferred on a cycle where req_i & gnt_o; gnt_o
// may drop while req_i is held. A FIFO entry leaves on a cycle where
// stdout_valid_o & stdout_ready_i; the head stays stable until then.
//
// Register map (addr_i[4:2]):
//   0 STDOUT       W: push wdata[7:0] when be[0]      R: FIFO occupancy
//   1 EXIT         W (be=F): first write latches the exit code
//   2 TEST_STATUS  W (be=F): PASS_MAGIC / FAIL_MAGIC set the sticky flags
//   3 CYCLE        W: clear counter                   R: counter value
//   4-7            W ignored                          R: 0

module cv32e40p_tb_ctrl_periph #(
  parameter int          FIFO_DEPTH = 16,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC = 32'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_char_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] SEL_STDOUT = 3'd0;
  localparam logic [2:0] SEL_EXIT   = 3'd1;
  localparam logic [2:0] SEL_STATUS = 3'd2;
  localparam logic [2:0] SEL_CYCLE  = 3'd3;

  logic [7:0]    lfsr_q, lfsr_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          passed_q, passed_d;
  logic          failed_q, failed_d;
  logic          exit_valid_q, exit_valid_d;
  logic [31:0]   exit_value_q, exit_value_d;

  logic [2:0] reg_sel;
  logic       stall, fifo_full, fifo_empty, stdout_wr;
  logic       wr_en, rd_en, push, pop;
  logic       unused_addr_bits;

  // Only the word index inside the 32-byte window matters.
  assign unused_addr_bits = ^{addr_i[31:5], addr_i[1:0]};

  always_comb begin
    reg_sel    = addr_i[4:2];
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    // Stall pattern is free-running; it does not depend on request activity.
    stall      = STALL_EN && (lfsr_q[1:0] == 2'b00);
    stdout_wr  = req_i & we_i & (reg_sel == SEL_STDOUT);
    // Full is the registered state: a pop in the same cycle does not open
    // room for a push until the following cycle.
    gnt_o      = req_i & ~stall & ~(stdout_wr & fifo_full);
    wr_en      = gnt_o & we_i;
    rd_en      = gnt_o & ~we_i;
    push       = wr_en & (reg_sel == SEL_STDOUT) & be_i[0];
    pop        = ~fifo_empty & stdout_ready_i;
  end

  always_comb begin
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cycle_d      = cycle_q + 32'd1;
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    mem_d        = mem_q;
    rvalid_d     = gnt_o;
    rdata_d      = '0;
    passed_d     = passed_q;
    failed_d     = failed_q;
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;

    if (push) begin
      mem_d[wptr_d] = wdata_i[7:0];
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Reads capture state as it is in the grant cycle.
    if (rd_en) begin
      case (reg_sel)
        SEL_STDOUT: rdata_d = 32'(count_q);
        SEL_CYCLE:  rdata_d = cycle_q;
        default:    rdata_d = '0;
      endcase
    end

    if (wr_en) begin
      case (reg_sel)
        SEL_EXIT: begin
          // Only the first full-word exit write is recorded.
          if (be_i == 4'hF && !exit_valid_q) begin
            exit_valid_d = 1'b1;
            exit_value_d = wdata_i;
          end
        end
        SEL_STATUS: begin
          if (be_i == 4'hF && wdata_i == PASS_MAGIC) passed_d = 1'b1;
          if (be_i == 4'hF && wdata_i == FAIL_MAGIC) failed_d = 1'b1;
        end
        SEL_CYCLE: cycle_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q       <= LFSR_SEED;
      cycle_q      <= '0;
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      cycle_q      <= cycle_d;
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign stdout_valid_o = ~fifo_empty;
  assign stdout_char_o  = fifo_empty ? 8'h00 : mem_q[rptr_q];
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule
